// File: rtl/mem_io_pkg.sv
// Shared constants and types for the CPU memory/IO responder.
package mem_io_pkg;

    typedef logic [7:0] byte_t;

    localparam logic [17:0] IO_PORT_ADDR = 18'h30000;
    localparam logic [17:0] IO_CLK_ADDR  = 18'h30004;
    localparam logic [1:0]  IO_REGION    = 2'b11;
    localparam logic [1:0]  OOB_REGION   = 2'b10;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with one extra pointer bit to tell full from empty.
// The head entry is read combinationally from storage.
module byte_fifo
    import mem_io_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  byte_t       push_data_i,
    input  logic        pop_i,
    output byte_t       head_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [AW:0] count_o
);
    byte_t       mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        push_ok, pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Full/empty are judged on the state before the edge, so a push into a
    // full FIFO is dropped even if a pop frees a slot in the same cycle.
    assign push_ok  = push_i && !full_o;
    assign pop_ok   = pop_i && !empty_o;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/mem_io_responder.sv
// Byte-bus responder: 128 KB RAM (1-cycle read), UART TX/RX FIFOs, cycle
// counter and halt flag. MEM_BOUNDS_CHECK_EN adds a sticky addr_err output.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int RAM_ADDR_W  = 17,
    parameter int FIFO_DEPTH  = 16,
    parameter int FULL_MARGIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_a,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        halt,
    output logic [31:0] cycle_cnt
`ifdef MEM_BOUNDS_CHECK_EN
    ,
    output logic        addr_err
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    byte_t                 mem_q [2**RAM_ADDR_W];
    byte_t                 ram_rdata_q;
    logic [RAM_ADDR_W-1:0] ram_idx;
    logic [17:0]           io_addr;
    logic                  is_io, ram_ok, ram_we;

    logic        ram_sel_q, ram_sel_d;
    byte_t       io_rdata_q, io_rdata_d;
    logic        halt_q, halt_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] snap_q, snap_d;
    logic        io_full_q, io_full_d;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    byte_t         tx_wdata, tx_head;
    logic [CW-1:0] tx_count, tx_count_next;
    logic          rx_push, rx_pop, rx_full, rx_empty;
    byte_t         rx_head;
    logic [CW-1:0] rx_count;
    logic          unused_bits;

    assign io_addr     = cpu_a[17:0];
    assign ram_idx     = cpu_a[RAM_ADDR_W-1:0];
    assign is_io       = (cpu_a[17:16] == IO_REGION);
    assign unused_bits = ^{cpu_a[31:18], rx_count};

`ifdef MEM_BOUNDS_CHECK_EN
    logic oob;
    logic addr_err_q;

    assign oob      = !is_io && ((cpu_a[17:16] == OOB_REGION) || (cpu_a[31:18] != '0));
    assign ram_ok   = !is_io && !oob;
    assign addr_err = addr_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_err_q <= 1'b0;
        else if (oob) addr_err_q <= 1'b1;
    end
`else
    assign ram_ok = !is_io;
`endif

    always_comb begin
        tx_push    = 1'b0;
        tx_wdata   = '0;
        rx_pop     = 1'b0;
        halt_d     = halt_q;
        snap_d     = snap_q;
        io_rdata_d = '0;
        ram_sel_d  = 1'b0;
        ram_we     = 1'b0;
        if (is_io) begin
            if (cpu_wr) begin
                if (!halt_q) begin
                    if (io_addr == IO_PORT_ADDR && cpu_dout != '0) begin
                        tx_push  = 1'b1;
                        tx_wdata = cpu_dout;
                    end else if (io_addr == IO_CLK_ADDR) begin
                        tx_push = 1'b1;
                        halt_d  = 1'b1;
                    end
                end
            end else begin
                // Byte 0 comes from the value being captured so all four
                // bytes of one snapshot agree.
                case (io_addr)
                    IO_PORT_ADDR: begin
                        if (!rx_empty) begin
                            rx_pop     = 1'b1;
                            io_rdata_d = rx_head;
                        end
                    end
                    IO_CLK_ADDR: begin
                        io_rdata_d = cnt_q[7:0];
                        snap_d     = cnt_q;
                    end
                    IO_CLK_ADDR + 18'd1: io_rdata_d = snap_q[15:8];
                    IO_CLK_ADDR + 18'd2: io_rdata_d = snap_q[23:16];
                    IO_CLK_ADDR + 18'd3: io_rdata_d = snap_q[31:24];
                    default: ;
                endcase
            end
        end else if (ram_ok) begin
            ram_we    = cpu_wr;
            ram_sel_d = !cpu_wr;
        end
    end

    assign tx_pop  = tx_valid && tx_ready;
    assign rx_push = rx_valid && rx_ready;

    // Occupancy after this edge, so the flag reflects the write just taken.
    assign tx_count_next = tx_count + CW'(tx_push && !tx_full) - CW'(tx_pop);
    assign io_full_d     = (FIFO_DEPTH - int'(tx_count_next)) <= FULL_MARGIN;
    assign cnt_d         = halt_q ? cnt_q : cnt_q + 32'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_sel_q  <= 1'b0;
            io_rdata_q <= '0;
            halt_q     <= 1'b0;
            cnt_q      <= '0;
            snap_q     <= '0;
            io_full_q  <= 1'b0;
        end else begin
            ram_sel_q  <= ram_sel_d;
            io_rdata_q <= io_rdata_d;
            halt_q     <= halt_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            io_full_q  <= io_full_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) mem_q[ram_idx] <= cpu_dout;
        ram_rdata_q <= mem_q[ram_idx];
    end

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (tx_push),
        .push_data_i (tx_wdata),
        .pop_i       (tx_pop),
        .head_o      (tx_head),
        .full_o      (tx_full),
        .empty_o     (tx_empty),
        .count_o     (tx_count)
    );

    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (rx_push),
        .push_data_i (rx_data),
        .pop_i       (rx_pop),
        .head_o      (rx_head),
        .full_o      (rx_full),
        .empty_o     (rx_empty),
        .count_o     (rx_count)
    );

    assign cpu_din        = ram_sel_q ? ram_rdata_q : io_rdata_q;
    assign io_buffer_full = io_full_q;
    assign tx_data        = tx_head;
    assign tx_valid       = !tx_empty;
    assign rx_ready       = !rx_full;
    assign halt           = halt_q;
    assign cycle_cnt      = cnt_q;

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-wide bus (address, write-enable, data-out, data-in, io_buffer_full).
- Provides the 128 KB program/data RAM with 1-cycle read latency.
- Provides memory-mapped I/O: UART TX/RX byte FIFOs, a free-running cycle counter and the program-stop flag.
- Sits at top level beside the CPU and the UART.

Parameters:
- RAM_ADDR_W, 17, RAM byte-address width (2^17 = 128 KB).
- FIFO_DEPTH, 16, entries per TX/RX FIFO; power of two, minimum 4.
- FULL_MARGIN, 2, TX free slots at or below which io_buffer_full asserts.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- cpu_a  in  32  byte address from CPU; only [17:0] decoded
- cpu_wr  in  1  1 = write, 0 = read
- cpu_dout  in  8  write data from CPU
- cpu_din  out  8  read data to CPU, registered
- io_buffer_full  out  1  TX FIFO near full
- tx_data  out  8  byte to UART transmitter
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  UART accepts tx_data this cycle
- rx_data  in  8  byte from UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  RX FIFO not full
- halt  out  1  sticky program-stop flag
- cycle_cnt  out  32  cycles elapsed since reset

Behaviour:
- Reset:
  - cpu_din=0, halt=0, cycle_cnt=0.
  - Both FIFOs empty: tx_valid=0, rx_ready=1, io_buffer_full=0.
  - Counter snapshot=0.
  - RAM contents are not reset.
- Decode: IO when cpu_a[17:16]==2'b11, otherwise RAM at cpu_a[RAM_ADDR_W-1:0].
- Every cycle is an access; there is no idle encoding.
- Reads: cpu_din is updated at the next posedge, i.e. valid one cycle after the address.
- RAM:
  - Write stores cpu_dout at the next posedge.
  - A read of an address written in the previous cycle returns the new data.
- 0x30000 read: pop RX head into cpu_din. If RX is empty, return 0x00 and do not pop.
- 0x30000 write:
  - cpu_dout != 0: push to TX; dropped silently if TX is full.
  - cpu_dout == 0: ignored.
- 0x30004 read: cpu_din = snapshot byte 0, and snapshot <= cycle_cnt (the value before this edge's increment).
- 0x30005/6/7 read: snapshot bytes 1/2/3, little-endian. Software reads 0x30004 first.
- 0x30004 write: push 0x00 to TX (if not full) and set halt.
  - Once halt=1, all further IO writes are ignored.
  - RAM writes and reads continue.
- Other IO addresses: reads return 0x00, writes are ignored.
- cycle_cnt:
  - Increments by 1 each cycle while halt=0; wraps modulo 2^32.
  - Frozen from the cycle after halt sets.
- FIFOs:
  - Circular buffers with log2(FIFO_DEPTH)+1-bit pointers.
  - Full when the pointers differ only in the MSB.
  - Push is accepted only when not full at the clock edge.
  - Simultaneous push and pop on a non-empty FIFO keeps the count unchanged.
  - Pop when empty is a no-op.
- TX drain: a pop occurs when tx_valid && tx_ready. tx_data is the head entry (combinational from storage).
- RX fill: a push occurs when rx_valid && rx_ready.
- io_buffer_full = (FIFO_DEPTH - tx_count) <= FULL_MARGIN, registered. The margin covers the CPU's in-flight writes.
- Reset mid-operation clears FIFOs, counter and halt immediately (asynchronous). The pending cpu_din is lost.

Optional Feature:
- Macro: MEM_BOUNDS_CHECK_EN.
- Defined:
  - Adds output addr_err (1 bit, reset 0, sticky).
  - Non-IO accesses with cpu_a[17:16]==2'b10, or cpu_a[31:18]!=0, set addr_err.
  - Such writes are suppressed; such reads return 0x00.
- Undefined:
  - No addr_err port.
  - Out-of-range addresses alias into RAM via cpu_a[RAM_ADDR_W-1:0].

Decomposition:
- Shared package mem_io_pkg:
  - IO_PORT_ADDR=18'h30000, IO_CLK_ADDR=18'h30004.
  - IO_REGION=2'b11.
  - Byte type typedef.
- Natural sub-module: byte_fifo (parameter DEPTH; push/pop/full/empty/count), instantiated twice (TX, RX).
- RAM stays an inferred array in the top.

Test Plan:
- RAM: write 0xA5 to 0x00100, then read 0x00100 in the next cycle -> cpu_din==0xA5 one cycle after the read address.
- TX: write 0x41, 0x00, 0x42 to 0x30000 with tx_ready=1 -> the UART receives exactly 0x41 then 0x42.
- Backpressure: tx_ready=0, write 14 nonzero bytes -> io_buffer_full=1 after the 14th (DEPTH 16, margin 2); the 17th write is dropped; release -> 16 bytes drain in order.
- RX: read 0x30000 with RX empty -> 0x00. Push 0x31, 0x32, then read twice -> 0x31, 0x32.
- Counter: after 1000 cycles, read 0x30004..0x30007 -> 0x000003E8-ish snapshot bytes, consistent with each other despite cycles elapsing.
- Halt: write 0x30004 -> TX receives 0x00, halt=1, cycle_cnt frozen, later writes to 0x30000 produce nothing. Assert rst mid-stream -> all outputs return to reset values the same cycle.
